// File: rtl/bus_pkg.sv
// Shared definitions for the bus master port: FSM encoding, idle address
// and the layout of a buffered request.
package bus_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] RD_ADDR = 2'd2;
    localparam logic [1:0] TURN    = 2'd3;

    localparam logic [7:0] IDLE_ADDR_DFLT = 8'hFF;

    localparam int unsigned REQ_WIDTH = 1 + 8 + 8;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous active-high reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bus_master_port.sv
// Initiator on the shared 8-bit bus: buffers client requests and sequences
// them as single-cycle writes or registered-read cycles followed by a turnaround.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [7:0]  IDLE_ADDR    = IDLE_ADDR_DFLT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WE,
    input  logic [7:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    output logic       RSP_VALID,
    output logic [7:0] RSP_RDATA,
    output logic       BUSY,
    inout  wire  [7:0] BUS_DATA,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WW = $clog2(READ_LATENCY);
    localparam logic [WW-1:0] WAIT_LAST = WW'(READ_LATENCY - 1);

    req_t                 req_in;
    req_t                 head;
    logic [REQ_WIDTH-1:0] head_bits;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_d;

    logic [1:0]    state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic          we_q, we_d;
    logic          drive_q, drive_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          busy_q, busy_d;

    assign req_in    = '{we: REQ_WE, addr: REQ_ADDR, wdata: REQ_WDATA};
    assign head      = req_t'(head_bits);
    assign REQ_READY = ~fifo_full;
    assign push      = REQ_VALID & REQ_READY;

    sync_fifo #(
        .WIDTH(REQ_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_req_fifo (
        .clk  (CLK),
        .reset(RESET),
        .push (push),
        .pop  (pop),
        .wdata(req_in),
        .rdata(head_bits),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        addr_d      = IDLE_ADDR;
        we_d        = 1'b0;
        drive_d     = 1'b0;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            // WRITE pops the next entry directly so writes run back-to-back.
            IDLE, WRITE: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    addr_d = head.addr;
                    wait_d = '0;
                    if (head.we) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        drive_d = 1'b1;
                        wdata_d = head.wdata;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (wait_q == WAIT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = BUS_DATA;
                    state_d     = TURN;
                end else begin
                    addr_d = addr_q;
                    wait_d = wait_q + WW'(1);
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = fifo_count;
        if (push && !pop) begin
            count_d = fifo_count + CW'(1);
        end else if (!push && pop) begin
            count_d = fifo_count - CW'(1);
        end
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            addr_q      <= IDLE_ADDR;
            we_q        <= 1'b0;
            drive_q     <= 1'b0;
            wdata_q     <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            drive_q     <= drive_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign BUS_DATA  = drive_q ? wdata_q : 8'hzz;
    assign BUS_ADDR  = addr_q;
    assign BUS_WE    = we_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: a four-register peripheral at D0..D3 with a
// registered read, and a scoreboard of expected bus writes and read responses.
module tb_bus_master_port;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_WE = 1'b0;
    logic [7:0] REQ_ADDR = 8'h00;
    logic [7:0] REQ_WDATA = 8'h00;
    logic       REQ_READY;
    logic       RSP_VALID;
    logic [7:0] RSP_RDATA;
    logic       BUSY;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         contention = 0;
    logic       saw_full = 1'b0;
    logic [7:0] reg_bank [4];
    logic [7:0] exp_mem [4];
    logic       resp_oe = 1'b0;
    logic [7:0] resp_data = 8'h00;
    logic       hit;

    always #5 CLK = ~CLK;

    bus_master_port dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WE   (REQ_WE),
        .REQ_ADDR (REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID),
        .RSP_RDATA(RSP_RDATA),
        .BUSY     (BUSY),
        .BUS_DATA (BUS_DATA),
        .BUS_ADDR (BUS_ADDR),
        .BUS_WE   (BUS_WE)
    );

    // Peripheral at D0..D3: write capture and one-cycle registered read.
    assign hit      = (BUS_ADDR[7:2] == 6'h34);
    assign BUS_DATA = resp_oe ? resp_data : 8'hzz;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RESET) begin
            resp_oe <= 1'b0;
        end else begin
            if (BUS_WE && hit) reg_bank[BUS_ADDR[1:0]] <= BUS_DATA;
            resp_oe   <= !BUS_WE && hit;
            resp_data <= reg_bank[BUS_ADDR[1:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RESET) begin
            if (BUS_WE && resp_oe) contention++;
            if (BUS_WE) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("wr_kind", {31'd0, e.we}, 32'd1);
                    check("wr_addr", {24'd0, BUS_ADDR}, {24'd0, e.addr});
                    check("wr_data", {24'd0, BUS_DATA}, {24'd0, e.data});
                end
            end
            if (RSP_VALID) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_kind", {31'd0, e.we}, 32'd0);
                    check("rsp_rdata", {24'd0, RSP_RDATA}, {24'd0, e.data});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] data);
        int   waits = 0;
        exp_t e;
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_ADDR  = addr;
        REQ_WDATA = data;
        while (!REQ_READY && waits < 100) begin
            @(negedge CLK);
            waits++;
        end
        if (waits >= 100) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            REQ_VALID = 1'b0;
            return;
        end
        if (waits > 0) saw_full = 1'b1;
        @(posedge CLK);
        if (we) exp_mem[addr[1:0]] = data;
        e.we   = we;
        e.addr = addr;
        e.data = we ? data : exp_mem[addr[1:0]];
        sb.push_back(e);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("drain", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int rd_acc;
        int n;

        repeat (3) @(negedge CLK);
        check("rst_addr", {24'd0, BUS_ADDR}, 32'hFF);
        check("rst_we", {31'd0, BUS_WE}, 32'd0);
        check("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
        check("rst_rsp_rdata", {24'd0, RSP_RDATA}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_ready", {31'd0, REQ_READY}, 32'd1);
        RESET = 1'b0;

        // Single write: one bus cycle at t1, then back to idle.
        send(1'b1, 8'hD2, 8'h07);
        check("t1_pre_we", {31'd0, BUS_WE}, 32'd0);
        check("t1_busy", {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        check("t1_addr", {24'd0, BUS_ADDR}, 32'hD2);
        check("t1_we", {31'd0, BUS_WE}, 32'd1);
        check("t1_data", {24'd0, BUS_DATA}, 32'h07);
        @(negedge CLK);
        check("t2_addr", {24'd0, BUS_ADDR}, 32'hFF);
        check("t2_we", {31'd0, BUS_WE}, 32'd0);
        check("t2_busy", {31'd0, BUSY}, 32'd0);
        check("t2_reg2", {24'd0, reg_bank[2]}, 32'h07);

        // Write then read back; response three cycles after acceptance.
        send(1'b1, 8'hD1, 8'h05);
        send(1'b0, 8'hD1, 8'h00);
        rd_acc = acc_cyc;
        n = 0;
        while (!RSP_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("rsp_seen", {31'd0, RSP_VALID}, 32'd1);
        check("rsp_latency", cyc - rd_acc, 32'd3);
        check("rsp_data", {24'd0, RSP_RDATA}, 32'h05);
        @(negedge CLK);
        check("rsp_pulse", {31'd0, RSP_VALID}, 32'd0);
        check("turn_addr", {24'd0, BUS_ADDR}, 32'hFF);
        check("turn_we", {31'd0, BUS_WE}, 32'd0);
        @(negedge CLK);
        check("rsp_held", {24'd0, RSP_RDATA}, 32'h05);
        wait_idle();

        // Fill the FIFO behind slow reads; everything completes in order.
        send(1'b1, 8'hD0, 8'h11);
        send(1'b1, 8'hD1, 8'h22);
        send(1'b1, 8'hD2, 8'h33);
        send(1'b1, 8'hD3, 8'h44);
        wait_idle();
        send(1'b0, 8'hD0, 8'h00);
        send(1'b0, 8'hD1, 8'h00);
        send(1'b0, 8'hD2, 8'h00);
        send(1'b0, 8'hD3, 8'h00);
        send(1'b0, 8'hD0, 8'h00);
        check("ready_low_when_full", {31'd0, REQ_READY}, 32'd0);
        send(1'b0, 8'hD1, 8'h00);
        check("fifo_filled", {31'd0, saw_full}, 32'd1);
        wait_idle();
        check("sb_drained", sb.size(), 32'd0);

        // Read immediately followed by a write to the same peripheral.
        send(1'b0, 8'hD2, 8'h00);
        send(1'b1, 8'hD2, 8'h99);
        wait_idle();
        @(negedge CLK);
        check("rw_reg2", {24'd0, reg_bank[2]}, 32'h99);

        // Reset mid-read with a write still queued.
        send(1'b0, 8'hD3, 8'h00);
        send(1'b1, 8'hD3, 8'h77);
        check("rd_addr_live", {24'd0, BUS_ADDR}, 32'hD3);
        RESET = 1'b1;
        sb.delete();
        @(negedge CLK);
        check("mid_rst_addr", {24'd0, BUS_ADDR}, 32'hFF);
        check("mid_rst_we", {31'd0, BUS_WE}, 32'd0);
        check("mid_rst_rsp", {31'd0, RSP_VALID}, 32'd0);
        check("mid_rst_rdata", {24'd0, RSP_RDATA}, 32'd0);
        check("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        check("mid_rst_ready", {31'd0, REQ_READY}, 32'd1);
        RESET = 1'b0;
        repeat (8) @(negedge CLK);
        check("post_rst_busy", {31'd0, BUSY}, 32'd0);
        check("post_rst_reg3", {24'd0, reg_bank[3]}, 32'h44);
        exp_mem[3] = 8'h44;

        // Back-to-back writes with no idle gap.
        send(1'b1, 8'hD0, 8'hA5);
        send(1'b1, 8'hD3, 8'h5A);
        check("b2b_first_addr", {24'd0, BUS_ADDR}, 32'hD0);
        check("b2b_first_we", {31'd0, BUS_WE}, 32'd1);
        @(negedge CLK);
        check("b2b_second_addr", {24'd0, BUS_ADDR}, 32'hD3);
        check("b2b_second_we", {31'd0, BUS_WE}, 32'd1);
        @(negedge CLK);
        check("b2b_end_we", {31'd0, BUS_WE}, 32'd0);
        check("b2b_reg0", {24'd0, reg_bank[0]}, 32'hA5);
        check("b2b_reg3", {24'd0, reg_bank[3]}, 32'h5A);

        wait_idle();
        check("sb_empty_end", sb.size(), 32'd0);
        check("no_contention", contention, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
